// File: rtl/key_debounce_8_if.sv
// Request bus between the key debouncer and its consumer (the 8-to-3 encoder side).
// The slave modport is the debouncer's view; the master modport is the driver/consumer view.
interface key_debounce_8_if;
    logic [7:0] key_in;
    logic [7:0] key_stable;
    logic [7:0] req_onehot;
    logic       req_valid;
    logic       req_ack;
    logic       overrun;

    modport master (
        output key_in,
        output req_ack,
        input  key_stable,
        input  req_onehot,
        input  req_valid,
        input  overrun
    );

    modport slave (
        input  key_in,
        input  req_ack,
        output key_stable,
        output req_onehot,
        output req_valid,
        output overrun
    );
endinterface

// File: rtl/key_debounce_8.sv
// Synchronises and debounces 8 key lines, queues rising edges as pending requests and
// presents them one at a time as a one-hot vector with a valid/ack handshake.
module key_debounce_8 #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    key_debounce_8_if.slave bus
);
    localparam int unsigned N = 8;

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_e;

    state_e               state_q, state_d;
    logic [N-1:0]         sync1_q, sync2_q;
    logic [CNT_W-1:0]     cnt_q [N];
    logic [CNT_W-1:0]     cnt_d [N];
    logic [N-1:0]         stable_q, stable_d;
    logic [N-1:0]         stable_prev_q;
    logic [N-1:0]         pend_q, pend_d;
    logic [N-1:0]         onehot_q, onehot_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic [N-1:0]         rise;
    logic [N-1:0]         lowest;
    logic [N-1:0]         grant;

    // Per-line debounce: flip only after DB_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Two's-complement trick isolates the lowest set pending bit.
    assign rise   = stable_q & ~stable_prev_q;
    assign lowest = pend_q & (~pend_q + N'(1));

    // Handshake FSM plus pending/overrun bookkeeping; a new rise beats a same-cycle grant.
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        grant    = '0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    grant    = lowest;
                    onehot_d = lowest;
                    valid_d  = 1'b1;
                    state_d  = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.req_ack) begin
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
        pend_d = (pend_q & ~grant) | rise;
        ovr_d  = ovr_q | (|(rise & pend_q & ~grant));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            pend_q        <= '0;
            onehot_q      <= '0;
            valid_q       <= 1'b0;
            ovr_q         <= 1'b0;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= bus.key_in;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pend_q        <= pend_d;
            onehot_q      <= onehot_d;
            valid_q       <= valid_d;
            ovr_q         <= ovr_d;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.key_stable = stable_q;
    assign bus.req_onehot = onehot_q;
    assign bus.req_valid  = valid_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_key_debounce_8.sv
// Directed bench for key_debounce_8: behavioural model checked every cycle plus
// hand-computed expectations for latency, ordering and overrun.
module tb_key_debounce_8;
    localparam int unsigned DB = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   started;

    key_debounce_8_if bus_if();

    key_debounce_8 #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Behavioural model: a line's level flips once the synchronised value has
    // disagreed with it on the last DB samples taken since its previous flip.
    logic [7:0]  m_s1, m_s2, m_stable, m_prev, m_pend, m_oh;
    logic        m_valid, m_ovr;
    logic [31:0] m_hist [8];
    int          m_since [8];

    initial begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pend = '0; m_oh = '0;
        m_valid = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 8; i++) begin m_hist[i] = '0; m_since[i] = 0; end
        forever begin
            logic [7:0] grant, rise, n_stable, n_oh;
            logic       n_valid;
            @(posedge clk);
            if (rst) begin
                started = 1'b1;
                m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pend = '0; m_oh = '0;
                m_valid = 1'b0; m_ovr = 1'b0;
                for (int i = 0; i < 8; i++) begin m_hist[i] = '0; m_since[i] = 0; end
            end else begin
                grant = '0; n_oh = m_oh; n_valid = m_valid;
                if (!m_valid) begin
                    for (int j = 7; j >= 0; j--) if (m_pend[j]) grant = 8'(1 << j);
                    if (grant != '0) begin n_oh = grant; n_valid = 1'b1; end
                end else if (bus_if.req_ack) begin
                    n_oh = '0; n_valid = 1'b0;
                end
                rise = m_stable & ~m_prev;
                if ((rise & m_pend & ~grant) != '0) m_ovr = 1'b1;
                m_pend = (m_pend & ~grant) | rise;
                n_stable = m_stable;
                for (int i = 0; i < 8; i++) begin
                    m_hist[i]  = {m_hist[i][30:0], m_s2[i] != m_stable[i]};
                    m_since[i] = m_since[i] + 1;
                    if (m_since[i] >= int'(DB) &&
                        (m_hist[i] & ((32'd1 << DB) - 32'd1)) == ((32'd1 << DB) - 32'd1)) begin
                        n_stable[i] = ~m_stable[i];
                        m_since[i]  = 0;
                    end
                end
                m_prev = m_stable; m_stable = n_stable;
                m_s2 = m_s1; m_s1 = bus_if.key_in;
                m_oh = n_oh; m_valid = n_valid;
            end
        end
    end

    // Per-cycle comparison against the model and the one-hot invariants.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                chk("key_stable", bus_if.key_stable, m_stable);
                chk("req_onehot", bus_if.req_onehot, m_oh);
                chk("req_valid",  bus_if.req_valid,  m_valid);
                chk("overrun",    bus_if.overrun,    m_ovr);
                chk("onehot_inv", $countones(bus_if.req_onehot) <= 1, 1);
                chk("valid_inv",  bus_if.req_onehot != '0, bus_if.req_valid);
            end
        end
    end

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.req_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus_if.req_ack = 1'b1;
        @(negedge clk);
        bus_if.req_ack = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            chk(nm, bus_if.req_valid, 0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; started = 1'b0;
        rst = 1'b1;
        bus_if.key_in  = 8'hFF;
        bus_if.req_ack = 1'b0;

        // Reset with all keys pressed, then release reset.
        repeat (2) @(negedge clk);
        chk("rst_stable", bus_if.key_stable, 0);
        chk("rst_onehot", bus_if.req_onehot, 0);
        chk("rst_valid",  bus_if.req_valid,  0);
        chk("rst_ovr",    bus_if.overrun,    0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("stable_edge4", bus_if.key_stable, 8'h00);
        @(posedge clk);
        #1 chk("stable_edge5", bus_if.key_stable, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            wait_valid(40);
            chk("drain_order", bus_if.req_onehot, 32'(1 << k));
            ack_pulse();
        end
        bus_if.key_in = 8'h00;
        idle_cycles(10, "post_drain_idle");

        // Single press: latency 7, held while no ack.
        @(negedge clk);
        bus_if.key_in = 8'h20;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1 chk("press_early", bus_if.req_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("press_edge7_valid",  bus_if.req_valid, 1);
        chk("press_edge7_onehot", bus_if.req_onehot, 8'h20);
        chk("press_enc",          enc(bus_if.req_onehot), 3'b101);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 chk("press_hold", bus_if.req_onehot, 8'h20);
        end
        ack_pulse();
        chk("press_ack_valid",  bus_if.req_valid, 0);
        chk("press_ack_onehot", bus_if.req_onehot, 0);
        bus_if.key_in = 8'h00;
        idle_cycles(10, "press_release_idle");

        // Glitch of 3 cycles on line 3 is rejected.
        @(negedge clk);
        bus_if.key_in = 8'h08;
        repeat (3) @(negedge clk);
        bus_if.key_in = 8'h00;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            chk("glitch_stable", bus_if.key_stable, 0);
            chk("glitch_valid",  bus_if.req_valid, 0);
        end

        // Lines 2 and 6 together: lowest first, second right after ack.
        @(negedge clk);
        bus_if.key_in = 8'h44;
        wait_valid(40);
        chk("prio_first", bus_if.req_onehot, 8'h04);
        @(negedge clk);
        bus_if.req_ack = 1'b1;
        @(posedge clk);
        #1 chk("prio_gap", bus_if.req_valid, 0);
        @(negedge clk);
        bus_if.req_ack = 1'b0;
        @(posedge clk);
        #1 chk("prio_second", bus_if.req_onehot, 8'h40);
        ack_pulse();
        idle_cycles(10, "prio_no_extra");
        bus_if.key_in = 8'h00;
        idle_cycles(10, "prio_release_idle");

        // Overrun: presented + pending + third press on line 1.
        @(negedge clk);
        bus_if.key_in = 8'h02;
        wait_valid(40);
        chk("ovr_first", bus_if.req_onehot, 8'h02);
        repeat (2) @(negedge clk);
        bus_if.key_in = 8'h00;
        repeat (8) @(negedge clk);
        bus_if.key_in = 8'h02;
        repeat (8) @(negedge clk);
        chk("ovr_not_yet", bus_if.overrun, 0);
        bus_if.key_in = 8'h00;
        repeat (8) @(negedge clk);
        bus_if.key_in = 8'h02;
        repeat (8) @(negedge clk);
        chk("ovr_set", bus_if.overrun, 1);
        chk("ovr_still_first", bus_if.req_onehot, 8'h02);
        ack_pulse();
        wait_valid(10);
        chk("ovr_second", bus_if.req_onehot, 8'h02);
        ack_pulse();
        idle_cycles(12, "ovr_no_dup");
        chk("ovr_sticky", bus_if.overrun, 1);
        bus_if.key_in = 8'h00;
        idle_cycles(10, "ovr_release_idle");

        // Reset in the middle of a presented request, key kept held.
        @(negedge clk);
        bus_if.key_in = 8'h10;
        wait_valid(40);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid",  bus_if.req_valid, 0);
        chk("midrst_onehot", bus_if.req_onehot, 0);
        chk("midrst_ovr",    bus_if.overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1 chk("midrst_early", bus_if.req_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("midrst_fresh_valid",  bus_if.req_valid, 1);
        chk("midrst_fresh_onehot", bus_if.req_onehot, 8'h10);
        ack_pulse();
        bus_if.key_in = 8'h00;
        idle_cycles(10, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
